// File: rtl/uart_pkg.sv
// Shared definitions for the UART pixel receive path.
//   rx_state_t    : receiver FSM states, also visible on the debug state outputs
//   RGB_*_W       : RGB565 field widths; PIXEL_W is their sum (16)
//   clks_per_bit(): system clocks per UART bit for a given clock and baud rate
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } rx_state_t;

  localparam int RGB_R_W = 5;
  localparam int RGB_G_W = 6;
  localparam int RGB_B_W = 5;
  localparam int PIXEL_W = RGB_R_W + RGB_G_W + RGB_B_W;

  // Integer division truncates: 100 MHz / 115200 gives 868. Callers must keep
  // the result at 4 or more so the half-bit count stays non-zero.
  function automatic int clks_per_bit(input int clk_hz, input int baud);
    return clk_hz / baud;
  endfunction

endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 UART byte receiver, LSB first.
//   clk, rst    : system clock, synchronous active-high reset
//   uart_rx     : asynchronous serial line, idle high
//   rx_byte     : last correctly framed byte (held between strobes)
//   byte_valid  : one-cycle strobe, rx_byte updates in the same cycle
//   frame_err   : one-cycle strobe when the stop bit is sampled low
//   state       : current FSM state, for debug and checkers
//
// Interface semantics: byte_valid and frame_err are pure strobes with no
// ready/backpressure; a consumer must take rx_byte in the strobe cycle or
// rely on it being held until the next good byte. The two never assert
// together.
module uart_rx_byte
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       uart_rx,
  output logic [7:0] rx_byte,
  output logic       byte_valid,
  output logic       frame_err,
  output rx_state_t  state
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(CLKS_PER_BIT - 1);

  // Two-flop synchronizer, reset to the idle level so reset never looks
  // like a start bit.
  logic rx_meta, rxs;

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rxs     <= 1'b1;
    end else begin
      rx_meta <= uart_rx;
      rxs     <= rx_meta;
    end
  end

  rx_state_t        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       idx_q, idx_d;
  logic [7:0]       shift_q, shift_d;
  logic [7:0]       rx_byte_q, rx_byte_d;
  logic             byte_valid_q, byte_valid_d;
  logic             frame_err_q, frame_err_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      idx_q        <= '0;
      shift_q      <= '0;
      rx_byte_q    <= '0;
      byte_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      shift_q      <= shift_d;
      rx_byte_q    <= rx_byte_d;
      byte_valid_q <= byte_valid_d;
      frame_err_q  <= frame_err_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    idx_d        = idx_q;
    shift_d      = shift_q;
    rx_byte_d    = rx_byte_q;
    byte_valid_d = 1'b0;
    frame_err_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (!rxs) begin
          state_d = START;
          cnt_d   = '0;
        end
      end

      // Wait half a bit to land in the middle of the start bit; a high
      // level there means the falling edge was a glitch.
      START: begin
        if (cnt_q == HALF_M1) begin
          cnt_d   = '0;
          idx_d   = '0;
          state_d = rxs ? IDLE : DATA;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      DATA: begin
        if (cnt_q == FULL_M1) begin
          cnt_d          = '0;
          shift_d[idx_q] = rxs;
          if (idx_q == 3'd7) begin
            state_d = STOP;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      // The stop bit is judged at its midpoint and the FSM leaves at once,
      // so a start bit following a short stop bit is still caught.
      STOP: begin
        if (cnt_q == FULL_M1) begin
          cnt_d   = '0;
          state_d = IDLE;
          if (rxs) begin
            byte_valid_d = 1'b1;
            rx_byte_d    = shift_q;
          end else begin
            frame_err_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      default: state_d = IDLE;
    endcase
  end

  assign rx_byte    = rx_byte_q;
  assign byte_valid = byte_valid_q;
  assign frame_err  = frame_err_q;
  assign state      = state_q;

endmodule

// File: rtl/uart_pixel_rx.sv
// UART receiver that pairs bytes into RGB565 pixels: {second byte, first byte}.
//   clk, rst    : system clock, synchronous active-high reset
//   uart_rx     : asynchronous serial line, idle high (8N1, LSB first)
//   rx_byte     : last correctly framed byte
//   byte_valid  : one-cycle strobe with rx_byte
//   pixel_out   : last assembled pixel, held until the next one
//   pixel_valid : one-cycle strobe, one cycle after the second byte_valid
//   frame_err   : one-cycle strobe on a low stop bit; drops any half pixel
//   rx_state    : receiver FSM state, for debug and checkers
//
// Interface semantics: all *_valid and frame_err outputs are strobes with no
// ready; there is no backpressure anywhere on this path.
module uart_pixel_rx
  import uart_pkg::*;
#(
  parameter int CLK_HZ = 100_000_000,
  parameter int BAUD   = 115200
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               uart_rx,
  output logic [7:0]         rx_byte,
  output logic               byte_valid,
  output logic [PIXEL_W-1:0] pixel_out,
  output logic               pixel_valid,
  output logic               frame_err,
  output rx_state_t          rx_state
);

  localparam int CLKS_PER_BIT = clks_per_bit(CLK_HZ, BAUD);

  uart_rx_byte #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_rx_byte (
    .clk        (clk),
    .rst        (rst),
    .uart_rx    (uart_rx),
    .rx_byte    (rx_byte),
    .byte_valid (byte_valid),
    .frame_err  (frame_err),
    .state      (rx_state)
  );

  // phase_q = 1 means a low byte is waiting for its partner.
  logic               phase_q;
  logic [7:0]         low_q;
  logic [PIXEL_W-1:0] pixel_q;
  logic               pixel_valid_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      phase_q       <= 1'b0;
      low_q         <= '0;
      pixel_q       <= '0;
      pixel_valid_q <= 1'b0;
    end else begin
      pixel_valid_q <= 1'b0;
      // A framing error always wins and realigns the pairing.
      if (frame_err) begin
        phase_q <= 1'b0;
      end else if (byte_valid) begin
        if (!phase_q) begin
          low_q   <= rx_byte;
          phase_q <= 1'b1;
        end else begin
          pixel_q       <= {rx_byte, low_q};
          pixel_valid_q <= 1'b1;
          phase_q       <= 1'b0;
        end
      end
    end
  end

  assign pixel_out   = pixel_q;
  assign pixel_valid = pixel_valid_q;

endmodule

// File: tb/tb_uart_pixel_rx.sv
module tb_uart_pixel_rx;
  import uart_pkg::*;

  localparam int CLK_HZ = 1_600_000;
  localparam int BAUD   = 100_000;
  localparam int CPB    = 16;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        uart_rx = 1'b1;
  logic [7:0]  rx_byte;
  logic        byte_valid;
  logic [15:0] pixel_out;
  logic        pixel_valid;
  logic        frame_err;
  rx_state_t   rx_state;

  always #5 clk = ~clk;

  uart_pixel_rx #(
    .CLK_HZ (CLK_HZ),
    .BAUD   (BAUD)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .uart_rx     (uart_rx),
    .rx_byte     (rx_byte),
    .byte_valid  (byte_valid),
    .pixel_out   (pixel_out),
    .pixel_valid (pixel_valid),
    .frame_err   (frame_err),
    .rx_state    (rx_state)
  );

  // ---------------- scoreboard state ----------------
  int          checks   = 0;
  int          failures = 0;
  logic [7:0]  exp_q[$];
  logic [15:0] exp_pix_q[$];
  int          ferr_pending = 0;
  logic [7:0]  held_byte = 8'h00;
  logic [15:0] held_pix  = 16'h0000;
  logic        have_low  = 1'b0;
  logic [7:0]  low_byte  = 8'h00;
  int          byte_cnt = 0;
  int          pix_cnt  = 0;
  int          ferr_cnt = 0;
  logic        prev_bv  = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Bytes arrive in send order; every second good byte completes a pixel
  // whose high half is the later byte. A bad frame or reset forgets any
  // waiting first byte.
  task automatic model_good(input logic [7:0] b);
    exp_q.push_back(b);
    if (have_low) begin
      exp_pix_q.push_back({b, low_byte});
      have_low = 1'b0;
    end else begin
      low_byte = b;
      have_low = 1'b1;
    end
  endtask

  task automatic model_bad();
    ferr_pending++;
    have_low = 1'b0;
  endtask

  task automatic model_reset();
    held_byte = 8'h00;
    held_pix  = 16'h0000;
    have_low  = 1'b0;
  endtask

  // ---------------- driver tasks (called at a negedge) ----------------
  task automatic drive_bit(input logic v, input int cycles);
    uart_rx = v;
    repeat (cycles) @(negedge clk);
  endtask

  task automatic send_raw(input logic [7:0] b, input logic stop, input int per);
    drive_bit(1'b0, per);
    for (int i = 0; i < 8; i++) drive_bit(b[i], per);
    drive_bit(stop, per);
    uart_rx = 1'b1;
  endtask

  task automatic send_byte(input logic [7:0] b, input int per);
    model_good(b);
    send_raw(b, 1'b1, per);
  endtask

  task automatic send_bad(input logic [7:0] b);
    model_bad();
    send_raw(b, 1'b0, CPB);
    drive_bit(1'b1, 2 * CPB);
  endtask

  // Bits alternate 15 and 17 cycles, so each bit is off by one cycle but
  // the edges never drift more than a cycle from nominal. A frame made of
  // only 15-cycle bits drifts ~9 cycles by the stop bit, past the mid-bit
  // sample point of any receiver at this ratio.
  task automatic send_jitter(input logic [7:0] b);
    logic [9:0] bits;
    bits = {1'b1, b, 1'b0};
    model_good(b);
    for (int i = 0; i < 10; i++) drive_bit(bits[i], (i % 2 == 0) ? 15 : 17);
    uart_rx = 1'b1;
  endtask

  task automatic idle(input int cycles);
    uart_rx = 1'b1;
    repeat (cycles) @(negedge clk);
  endtask

  // ---------------- compare process ----------------
  initial begin
    logic [7:0]  eb;
    logic [15:0] ep;
    forever begin
      @(posedge clk);
      #1;
      if (byte_valid) begin
        byte_cnt++;
        if (exp_q.size() == 0) begin
          check("unexpected_byte_valid", 32'(rx_byte), 32'hFFFF_FFFF);
        end else begin
          eb = exp_q.pop_front();
          check("rx_byte", 32'(rx_byte), 32'(eb));
          held_byte = eb;
        end
      end else begin
        check("rx_byte_hold", 32'(rx_byte), 32'(held_byte));
      end
      if (pixel_valid) begin
        pix_cnt++;
        check("pixel_latency", 32'(prev_bv), 32'd1);
        if (exp_pix_q.size() == 0) begin
          check("unexpected_pixel_valid", 32'(pixel_out), 32'hFFFF_FFFF);
        end else begin
          ep = exp_pix_q.pop_front();
          check("pixel_out", 32'(pixel_out), 32'(ep));
          held_pix = ep;
        end
      end else begin
        check("pixel_hold", 32'(pixel_out), 32'(held_pix));
      end
      if (frame_err) begin
        ferr_cnt++;
        check("frame_err_expected", 32'(ferr_pending > 0), 32'd1);
        check("frame_err_overlap", 32'(byte_valid), 32'd0);
        if (ferr_pending > 0) ferr_pending--;
      end
      prev_bv = byte_valid;
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int b0, p0, f0;
    logic [7:0] rb;

    repeat (4) @(negedge clk);
    check("reset_rx_byte", 32'(rx_byte), 32'h0);
    check("reset_pixel_out", 32'(pixel_out), 32'h0);
    check("reset_strobes", {29'd0, byte_valid, pixel_valid, frame_err}, 32'h0);
    check("reset_state", 32'(rx_state), 32'(IDLE));
    rst = 1'b0;
    idle(10);

    // 1: 0x34, one-bit gap, 0x12
    b0 = byte_cnt; p0 = pix_cnt;
    send_byte(8'h34, CPB);
    idle(CPB);
    send_byte(8'h12, CPB);
    idle(20);
    check("t1_bytes", 32'(byte_cnt - b0), 32'd2);
    check("t1_pixels", 32'(pix_cnt - p0), 32'd1);
    check("t1_pixel_value", 32'(pixel_out), 32'h1234);

    // 2: back-to-back AA 55 0F F0
    p0 = pix_cnt; f0 = ferr_cnt;
    send_byte(8'hAA, CPB);
    send_byte(8'h55, CPB);
    send_byte(8'h0F, CPB);
    send_byte(8'hF0, CPB);
    idle(20);
    check("t2_pixels", 32'(pix_cnt - p0), 32'd2);
    check("t2_last_pixel", 32'(pixel_out), 32'hF00F);
    check("t2_no_frame_err", 32'(ferr_cnt - f0), 32'd0);

    // 3: four-cycle glitch
    b0 = byte_cnt; f0 = ferr_cnt;
    drive_bit(1'b0, 4);
    check("t3_start_seen", 32'(rx_state), 32'(START));
    idle(40);
    check("t3_no_byte", 32'(byte_cnt - b0), 32'd0);
    check("t3_no_frame_err", 32'(ferr_cnt - f0), 32'd0);
    check("t3_idle", 32'(rx_state), 32'(IDLE));

    // 4: framing error drops the half pixel
    p0 = pix_cnt; f0 = ferr_cnt;
    send_byte(8'h34, CPB);
    send_bad(8'h12);
    check("t4_frame_err_once", 32'(ferr_cnt - f0), 32'd1);
    check("t4_no_pixel", 32'(pix_cnt - p0), 32'd0);
    check("t4_rx_byte_kept", 32'(rx_byte), 32'h34);
    send_byte(8'h78, CPB);
    send_byte(8'h56, CPB);
    idle(20);
    check("t4_pixel", 32'(pixel_out), 32'h5678);

    // 5: reset during bit 4 of the second byte of a pair
    send_byte(8'h11, CPB);
    b0 = byte_cnt; p0 = pix_cnt;
    rb = 8'h22;
    drive_bit(1'b0, CPB);
    for (int i = 0; i < 4; i++) drive_bit(rb[i], CPB);
    drive_bit(rb[4], CPB / 2);
    rst = 1'b1;
    uart_rx = 1'b1;
    model_reset();
    @(posedge clk);
    #1;
    check("t5_state_idle", 32'(rx_state), 32'(IDLE));
    check("t5_pixel_cleared", 32'(pixel_out), 32'h0);
    @(negedge clk);
    idle(3);
    rst = 1'b0;
    idle(20);
    check("t5_no_strobe", 32'(byte_cnt - b0 + pix_cnt - p0), 32'd0);
    send_byte(8'hCD, CPB);
    send_byte(8'hAB, CPB);
    idle(20);
    check("t5_pixel", 32'(pixel_out), 32'hABCD);

    // 6: baud tolerance
    b0 = byte_cnt;
    send_byte(8'hA5, 17);
    idle(20);
    check("t6_slow_byte", 32'(rx_byte), 32'hA5);
    send_jitter(8'hA5);
    idle(20);
    check("t6_jitter_byte", 32'(rx_byte), 32'hA5);
    check("t6_bytes", 32'(byte_cnt - b0), 32'd2);

    // randomized traffic, occasional framing errors
    for (int n = 0; n < 16; n++) begin
      rb = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 7) == 0) send_bad(rb);
      else send_byte(rb, CPB);
      idle($urandom_range(0, 20));
    end

    idle(200);
    check("drain_bytes", 32'(exp_q.size()), 32'd0);
    check("drain_pixels", 32'(exp_pix_q.size()), 32'd0);
    check("drain_frame_err", 32'(ferr_pending), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
